bsg_dff_chain_reset_en: RTL and testbench

- Parametrised successor to the single-stage enabled reset flop: an `els_p`-deep chain of enabled, resettable pipeline registers.
- Each stage carries a valid bit alongside its data.
- Adds a global advance enable, a synchronous flush that kills in-flight valids, and an occupancy count.
- Sits between datapath stages that must be retimed by a fixed, stallable number of cycles.

---
 rtl/bsg_dff_chain_reset_en.sv | 69 ++++++
 tb/tb_bsg_dff_chain_reset_en.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bsg_dff_chain_reset_en.sv
// Stallable, flushable chain of els_p enabled reset registers, each carrying a
// valid bit with its data, plus a registered count of valid stages.
module bsg_dff_chain_reset_en #(
    parameter int unsigned       width_p     = 64,
    parameter int unsigned       els_p       = 4,
    parameter logic [width_p-1:0] reset_val_p = '0,
    localparam int unsigned      count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      en_i,
    input  logic                      flush_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    output logic [count_width_lp-1:0] count_o
);

    logic [els_p-1:0]               valid_r, valid_n;
    logic [width_p-1:0]             data_r [els_p];
    logic [width_p-1:0]             data_n [els_p];
    logic [count_width_lp-1:0]      count_r, count_n;

    always_comb begin
        valid_n = valid_r;
        for (int unsigned k = 0; k < els_p; k++) begin
            data_n[k] = data_r[k];
        end

        if (flush_i) begin
            valid_n = '0;
        end else if (en_i) begin
            valid_n[0] = v_i;
            data_n[0]  = data_i;
            for (int unsigned k = 1; k < els_p; k++) begin
                valid_n[k] = valid_r[k-1];
                data_n[k]  = data_r[k-1];
            end
        end

        // Count is taken from next-state valids so the register tracks valid_r exactly.
        count_n = '0;
        for (int unsigned k = 0; k < els_p; k++) begin
            count_n = count_n + count_width_lp'(valid_n[k]);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r <= '0;
            count_r <= '0;
            for (int unsigned k = 0; k < els_p; k++) begin
                data_r[k] <= reset_val_p;
            end
        end else begin
            valid_r <= valid_n;
            count_r <= count_n;
            for (int unsigned k = 0; k < els_p; k++) begin
                data_r[k] <= data_n[k];
            end
        end
    end

    assign v_o     = valid_r[els_p-1];
    assign data_o  = data_r[els_p-1];
    assign count_o = count_r;

endmodule

// File: tb/tb_bsg_dff_chain_reset_en.sv
// Drives a 4-deep and a 1-deep chain with identical stimulus and checks both
// against a history-of-advances reference model.
module tb_bsg_dff_chain_reset_en;

    localparam logic [63:0] RV_A = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] RV_B = 64'h0000_0000_0000_CAFE;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        en_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        v_i = 1'b0;
    logic [63:0] data_i = '0;

    logic        v_a, v_b;
    logic [63:0] data_a, data_b;
    logic [2:0]  count_a;
    logic [0:0]  count_b;

    int checks = 0;
    int fails  = 0;

    // Every advancing edge since the last reset, oldest first.
    logic        hv [$];
    logic [63:0] hd [$];

    always #5 clk_i = ~clk_i;

    bsg_dff_chain_reset_en #(.width_p(64), .els_p(4), .reset_val_p(RV_A)) dut_a (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
        .v_i(v_i), .data_i(data_i), .v_o(v_a), .data_o(data_a), .count_o(count_a)
    );

    bsg_dff_chain_reset_en #(.width_p(64), .els_p(1), .reset_val_p(RV_B)) dut_b (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
        .v_i(v_i), .data_i(data_i), .v_o(v_b), .data_o(data_b), .count_o(count_b)
    );

    function automatic logic exp_v(int depth);
        int n = hv.size();
        return (n < depth) ? 1'b0 : hv[n-depth];
    endfunction

    function automatic logic [63:0] exp_d(int depth, logic [63:0] rv);
        int n = hd.size();
        return (n < depth) ? rv : hd[n-depth];
    endfunction

    function automatic int exp_cnt(int depth);
        int n = hv.size();
        int c = 0;
        for (int i = 0; i < depth; i++) begin
            if (n - 1 - i >= 0 && hv[n-1-i]) c++;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " A.v"},     {63'd0, v_a},     {63'd0, exp_v(4)});
        chk({tag, " A.data"},  data_a,           exp_d(4, RV_A));
        chk({tag, " A.count"}, {61'd0, count_a}, 64'(exp_cnt(4)));
        chk({tag, " B.v"},     {63'd0, v_b},     {63'd0, exp_v(1)});
        chk({tag, " B.data"},  data_b,           exp_d(1, RV_B));
        chk({tag, " B.count"}, {63'd0, count_b}, 64'(exp_cnt(1)));
    endtask

    task automatic step(input string tag, input logic e, input logic f,
                        input logic v, input logic [63:0] d);
        en_i = e; flush_i = f; v_i = v; data_i = d;
        @(posedge clk_i);
        if (!reset_i) begin
            if (f) begin
                foreach (hv[i]) hv[i] = 1'b0;
            end else if (e) begin
                hv.push_back(v);
                hd.push_back(d);
            end
        end
        #1 check_all(tag);
    endtask

    // Asserts reset between edges, checks it took effect before any edge, holds across one edge.
    task automatic pulse_reset(input string tag);
        en_i = $urandom_range(0, 1); flush_i = $urandom_range(0, 1);
        v_i = 1'b1; data_i = {$urandom, $urandom};
        #2 reset_i = 1'b1;
        hv.delete(); hd.delete();
        #1 check_all({tag, " async"});
        @(posedge clk_i);
        #1 check_all({tag, " held"});
        #1 reset_i = 1'b0;
    endtask

    initial begin
        // Reset with no clock edge in between.
        pulse_reset("reset");
        chk("reset A.data const", data_a, RV_A);

        // Latency: 0x11,0x22,0x33 then bubbles.
        step("lat1", 1, 0, 1, 64'h11);
        step("lat2", 1, 0, 1, 64'h22);
        step("lat3", 1, 0, 1, 64'h33);
        for (int i = 0; i < 4; i++) begin
            step("lat_drain", 1, 0, 0, {$urandom, $urandom});
            if (i == 0) chk("lat first out", data_a, 64'h11);
        end

        // Stall: one item, 5 frozen cycles, then resume.
        step("stall_load", 1, 0, 1, 64'hA5);
        for (int i = 0; i < 5; i++) begin
            step("stall_hold", 0, 0, $urandom_range(0, 1), {$urandom, $urandom});
        end
        for (int i = 0; i < 3; i++) begin
            step("stall_resume", 1, 0, 0, {$urandom, $urandom});
        end
        chk("stall out v", {63'd0, v_a}, 64'd1);
        chk("stall out data", data_a, 64'hA5);
        step("stall_exit", 1, 0, 0, 64'h0);

        // Flush beats enable.
        step("fl_fill", 1, 0, 1, 64'h101);
        step("fl_fill", 1, 0, 1, 64'h202);
        step("fl_fill", 1, 0, 1, 64'h303);
        step("flush", 1, 1, 1, 64'h77);
        chk("flush count", {61'd0, count_a}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step("fl_after", 1, 0, 0, 64'h0);
        end

        // Reset mid-stream with full pipeline.
        for (int i = 0; i < 4; i++) begin
            step("rs_fill", 1, 0, 1, {$urandom, $urandom});
        end
        chk("rs full count", {61'd0, count_a}, 64'd4);
        pulse_reset("rs_mid");
        step("rs_item", 1, 0, 1, 64'h5A);
        for (int i = 0; i < 3; i++) begin
            step("rs_drain", 1, 0, 0, {$urandom, $urandom});
        end
        chk("rs item v", {63'd0, v_a}, 64'd1);
        chk("rs item data", data_a, 64'h5A);

        // Degenerate depth-1 directed pair.
        step("deg_load", 1, 0, 1, 64'h3C);
        chk("deg data", data_b, 64'h3C);
        step("deg_empty", 1, 0, 0, 64'h0);
        chk("deg count", {63'd0, count_b}, 64'd0);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset("rnd_reset");
            end else begin
                step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 1), {$urandom, $urandom});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
